// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared types for the frequency meter sequencer: FSM state
//               encoding, gate range codes and the gate-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

    localparam logic [1:0] RANGE_1S    = 2'b00;
    localparam logic [1:0] RANGE_100MS = 2'b01;
    localparam logic [1:0] RANGE_10MS  = 2'b10;
    localparam logic [1:0] RANGE_RSVD  = 2'b11;

    // Reserved code falls back to the 1 s window.
    function automatic int gate_len(input logic [1:0] rng, input int clk_hz);
        case (rng)
            RANGE_100MS: return clk_hz / 10;
            RANGE_10MS:  return clk_hz / 100;
            default:     return clk_hz;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
// ============================================================================
// Module      : gate_timer
// Description : Loadable down-counter shared by the CLEAR, GATE and SETTLE
//               phases; done is high while the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : freq_gate_ctrl
// Description : Measurement sequencer for the BCD counter chain: clear pulse,
//               exact gate window, settle delay and result latch.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DIGITS     = 6,
    parameter int SETTLE_CYC = 16,
    parameter int CLEAR_CYC  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [1:0]            range_sel,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  gate_en,
    output logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [1:0]            range_out,
    output logic                  valid,
    output logic                  busy
);

    localparam int MAX_LEN = (CLK_HZ > CLEAR_CYC) ? CLK_HZ : CLEAR_CYC;
    localparam int TW      = $clog2(MAX_LEN) + 1;

    localparam logic [TW-1:0] CLEAR_LOAD  = TW'(CLEAR_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);

    state_t         state;
    state_t         state_n;
    logic           tmr_load;
    logic [TW-1:0]  tmr_value;
    logic           tmr_done;
    logic [1:0]     range_q;

    gate_timer #(.W(TW)) u_gate_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Timer is loaded on the transition edge so each phase lasts exactly
    // load+1 cycles; gate length uses range_sel because it is captured on
    // that same edge.
    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_n   = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_value = CLEAR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_n   = ST_GATE;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(gate_len(range_sel, CLK_HZ) - 1);
                end
            end
            ST_GATE: begin
                if (tmr_done) begin
                    state_n   = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_n = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (run) begin
                    state_n   = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_value = CLEAR_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_en   <= 1'b0;
            clear     <= 1'b0;
            valid     <= 1'b0;
            bcd_out   <= '0;
            range_out <= 2'b00;
            range_q   <= 2'b00;
        end else begin
            gate_en <= (state_n == ST_GATE);
            clear   <= (state_n == ST_CLEAR);
            valid   <= (state == ST_LATCH);
            if (state == ST_CLEAR && tmr_done) begin
                range_q <= range_sel;
            end
            if (state == ST_LATCH) begin
                bcd_out   <= bcd_in;
                range_out <= range_q;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire
